roll_history: RTL and testbench
===============================

# roll_history

Downstream stage of the random-number generator on the DE2-115 board. It captures each settled generator result on a done strobe, keeps the last `DEPTH` results in a shift buffer (newest first), and lets the user scroll through them. After each new capture, it produces a blink mask so the newest result flashes on the seven-segment display. Its outputs feed the hex decoders directly.

## Interface
- `DEPTH`, default 4: number of stored results (power of two, 2..8).
- `VALUE_W`, default 4: width of one result.
- `BLINK_HALF`, default 12_500_000: cycles per blink half-period (0.25 s at 50 MHz).
- `BLINK_TOGGLES`, default 6: number of half-periods per blink burst (must be even).
- `i_clk`, in, 1: the only clock, 50 MHz. All logic is on the rising edge.
- `i_rst`, in, 1: reset, synchronous, active-low. Clears all state.
- `i_value`, in, `VALUE_W`: current generator output.
- `i_done`, in, 1: one-cycle pulse; `i_value` is final in this same cycle.
- `i_clear`, in, 1: one-cycle pulse; empties the history.
- `i_prev`, in, 1: one-cycle pulse, driven by the debounced key; steps the selected entry to the next-older one.
- `o_sel_value`, out, `VALUE_W`: the selected entry, or 0 when the history is empty.
- `o_sel_idx`, out, `$clog2(DEPTH)`: age index of the selected entry (0 = newest).
- `o_count`, out, `$clog2(DEPTH)+1`: number of valid entries, 0..`DEPTH`.
- `o_full`, out, 1: `o_count == DEPTH`.
- `o_blank`, out, 1: 1 means the display should blank the selected digit (blink phase).

## Operation
- Storage is `hist[0..DEPTH-1]`, where `hist[0]` is the newest entry.
- Push (on `i_done`):
  - `hist[k] <= hist[k-1]` for k ≥ 1, and `hist[0] <= i_value`.
  - When full, the oldest entry is discarded.
  - `o_count` increments and saturates at `DEPTH`.
  - `o_sel_idx` is forced to 0.
- Clear (on `i_clear`):
  - `o_count` and `o_sel_idx` are set to 0.
  - Entries are zeroed.
  - The blink FSM returns to IDLE.
- Scroll (on `i_prev`):
  - `o_sel_idx <= (o_sel_idx + 1 == o_count) ? 0 : o_sel_idx + 1`.
  - With `o_count == 0`, `o_sel_idx` stays 0.
- Priority of simultaneous pulses in one cycle is clear > push > scroll.
  - Lower-priority pulses in that cycle are dropped, not deferred.
- `o_sel_value = (o_count == 0) ? 0 : hist[o_sel_idx]`. This output is combinational from registers.
- Blink FSM states:
  - IDLE: `o_blank = 0`.
  - BLINK: `o_blank` follows the phase register.
- Blink FSM transitions:
  - IDLE → BLINK on push. Load `half_cnt = 0`, `tog_cnt = 0`, phase = 1 (blank first).
  - In BLINK, when `half_cnt == BLINK_HALF-1`: `half_cnt <= 0`, phase toggles, `tog_cnt++`. Otherwise `half_cnt++`.
  - BLINK → IDLE when `tog_cnt` would reach `BLINK_TOGGLES`. Phase is 0 on exit.
  - A push while in BLINK restarts the burst: counters are reloaded and phase = 1.
  - A clear in any state goes to IDLE.
  - A scroll does not affect the FSM. Blink applies to whatever entry is selected.

## Timing
- All register outputs take effect the cycle after the triggering pulse; there is no other latency.
- Reset values:
  - every `hist` entry = 0
  - `o_count` = 0, `o_sel_idx` = 0, `o_sel_value` = 0
  - `o_full` = 0, `o_blank` = 0
  - FSM in IDLE, counters at 0
- Reset asserted mid-burst or mid-operation takes effect at the next edge and overrides all pulses.
- Blink burst length after a push:
  - `o_blank` is 1 for cycles 1..`BLINK_HALF`, 0 for the next `BLINK_HALF`, and so on.
  - `BLINK_TOGGLES*BLINK_HALF` cycles after the push the FSM is in IDLE with `o_blank = 0`.
- Inputs are treated as single-cycle pulses. A level held N cycles acts as N pulses; upstream must deliver edges.

## Structure
- Shared package `roll_pkg`:
  - `blink_state_t` enum {IDLE, BLINK}
  - `VALUE_W` default constant
  - `result_t` typedef (`logic [VALUE_W-1:0]`)
- Sub-module `blink_timer`:
  - contains the FSM, `half_cnt`, `tog_cnt` and phase
  - inputs: `i_clk`, `i_rst`, start, abort
  - output: `o_blank`
- The top of `roll_history` holds the shift buffer, count/select logic and priority decode.

## Test plan
Bench parameters are `BLINK_HALF = 4` and `BLINK_TOGGLES = 6`.
1. Reset, then idle 10 cycles → all outputs 0, `o_blank` 0.
2. Push 3, 7, 9, 2, 5 (`DEPTH = 4`) → `hist` = {5,2,9,7}, `o_count` = 4, `o_full` = 1, `o_sel_value` = 5.
3. After scenario 2, apply 5 `i_prev` pulses → `o_sel_idx` 1,2,3,0,1 and `o_sel_value` 2,9,7,5,2. Then push 8 → `o_sel_idx` = 0, `o_sel_value` = 8.
4. Push 6 and check `o_blank` → pattern 1×4, 0×4, 1×4, 0×4, 1×4, 0×4, then 0 forever. A push of 1 at cycle 10 restarts the burst with blank = 1 from cycle 11.
5. `i_clear`, `i_done` (value 4) and `i_prev` in the same cycle with the history full → `o_count` = 0, `o_sel_value` = 0, `o_blank` = 0. Value 4 is not stored.
6. Reset asserted during a blink with `o_count` = 2 → the next cycle shows every reset value. A following push of 3 gives `o_count` = 1 and `o_sel_value` = 3.

Source files
------------

// File: rtl/roll_pkg.sv
// Shared types and defaults for the roll history / blink path of the RNG display.
package roll_pkg;

  localparam int VALUE_W = 4;

  typedef logic [VALUE_W-1:0] result_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } blink_state_t;

endpackage

// File: rtl/roll_history_blink_timer.sv
// Blink burst generator: after a start pulse the blank output alternates
// on/off every BLINK_HALF cycles, beginning blanked, for BLINK_TOGGLES
// half-periods, then rests unblanked until the next start.
module blink_timer
  import roll_pkg::*;
#(
  parameter int BLINK_HALF    = 12_500_000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_abort,
  output logic o_blank
);

  localparam int HALF_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TOG_W  = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BLINK_HALF - 1);
  localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(BLINK_TOGGLES - 1);

  blink_state_t      state_q;
  logic [HALF_W-1:0] half_cnt_q;
  logic [TOG_W-1:0]  tog_cnt_q;
  logic              phase_q;

  // Burst FSM: abort beats start, start (re)loads the burst, otherwise count.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      half_cnt_q <= '0;
      tog_cnt_q  <= '0;
      phase_q    <= 1'b0;
    end else if (i_abort) begin
      state_q    <= IDLE;
      half_cnt_q <= '0;
      tog_cnt_q  <= '0;
      phase_q    <= 1'b0;
    end else if (i_start) begin
      state_q    <= BLINK;
      half_cnt_q <= '0;
      tog_cnt_q  <= '0;
      phase_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          phase_q <= 1'b0;
        end
        BLINK: begin
          if (half_cnt_q == HALF_LAST) begin
            half_cnt_q <= '0;
            if (tog_cnt_q == TOG_LAST) begin
              // Final toggle: the burst ends unblanked.
              state_q   <= IDLE;
              tog_cnt_q <= '0;
              phase_q   <= 1'b0;
            end else begin
              tog_cnt_q <= tog_cnt_q + 1'b1;
              phase_q   <= ~phase_q;
            end
          end else begin
            half_cnt_q <= half_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= 1'b0;
        end
      endcase
    end
  end

  // Phase is held at 0 whenever the FSM is idle, so it drives blank directly.
  assign o_blank = phase_q;

endmodule

// File: rtl/roll_history.sv
// History of the last DEPTH generator results (newest first) with a scroll
// selector and a blink burst flagging the newest capture on the display.
module roll_history #(
  parameter int DEPTH         = 4,
  parameter int VALUE_W       = roll_pkg::VALUE_W,
  parameter int BLINK_HALF    = 12_500_000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [VALUE_W-1:0]         i_value,
  input  logic                       i_done,
  input  logic                       i_clear,
  input  logic                       i_prev,
  output logic [VALUE_W-1:0]         o_sel_value,
  output logic [$clog2(DEPTH)-1:0]   o_sel_idx,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_blank
);

  import roll_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [VALUE_W-1:0] hist_q [DEPTH];
  logic [VALUE_W-1:0] hist_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   sel_q, sel_d;

  logic do_clear;
  logic do_push;
  logic do_prev;

  // One action per cycle: clear wins over push, push over scroll; losers are dropped.
  assign do_clear = i_clear;
  assign do_push  = i_done & ~i_clear;
  assign do_prev  = i_prev & ~i_clear & ~i_done;

  // Next-state for the shift buffer, entry count and selection index.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      hist_d[k] = hist_q[k];
    end
    count_d = count_q;
    sel_d   = sel_q;

    if (do_clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_d[k] = '0;
      end
      count_d = '0;
      sel_d   = '0;
    end else if (do_push) begin
      for (int k = 1; k < DEPTH; k++) begin
        hist_d[k] = hist_q[k-1];
      end
      hist_d[0] = i_value;
      if (count_q != CNT_MAX) begin
        count_d = count_q + 1'b1;
      end
      sel_d = '0;
    end else if (do_prev) begin
      if (count_q == '0) begin
        sel_d = '0;
      end else if ((CNT_W'(sel_q) + CNT_W'(1)) == count_q) begin
        sel_d = '0;
      end else begin
        sel_d = sel_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= '0;
      end
      count_q <= '0;
      sel_q   <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= hist_d[k];
      end
      count_q <= count_d;
      sel_q   <= sel_d;
    end
  end

  blink_timer #(
    .BLINK_HALF    (BLINK_HALF),
    .BLINK_TOGGLES (BLINK_TOGGLES)
  ) u_blink (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (do_push),
    .i_abort (do_clear),
    .o_blank (o_blank)
  );

  // Selected entry; shows 0 while the history is empty.
  always_comb begin
    o_sel_value = '0;
    if (count_q != '0) begin
      o_sel_value = hist_q[sel_q];
    end
  end

  assign o_sel_idx = sel_q;
  assign o_count   = count_q;
  assign o_full    = (count_q == CNT_MAX);

endmodule

// File: tb/tb_roll_history.sv
// Bench for roll_history: directed scenarios plus randomized pulses checked
// against a list-based reference model of the history and blink burst.
module tb_roll_history;

  localparam int DEPTH   = 4;
  localparam int VALUE_W = 4;
  localparam int HALF    = 4;
  localparam int TOGS    = 6;
  localparam int BURST   = HALF * TOGS;

  logic               clk = 1'b0;
  logic               i_rst = 1'b0;
  logic [VALUE_W-1:0] i_value = '0;
  logic               i_done = 1'b0;
  logic               i_clear = 1'b0;
  logic               i_prev = 1'b0;
  logic [VALUE_W-1:0] o_sel_value;
  logic [1:0]         o_sel_idx;
  logic [2:0]         o_count;
  logic               o_full;
  logic               o_blank;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: newest-first list, count, selection, cycles since push.
  int m_hist [DEPTH];
  int m_count;
  int m_sel;
  int m_age;   // 0 = no burst, n = n-th cycle after the capturing edge

  roll_history #(
    .DEPTH         (DEPTH),
    .VALUE_W       (VALUE_W),
    .BLINK_HALF    (HALF),
    .BLINK_TOGGLES (TOGS)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_value     (i_value),
    .i_done      (i_done),
    .i_clear     (i_clear),
    .i_prev      (i_prev),
    .o_sel_value (o_sel_value),
    .o_sel_idx   (o_sel_idx),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_blank     (o_blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit exp_blank(input int age);
    return (age >= 1) && (age <= BURST) && (((age - 1) / HALF) % 2 == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m_hist[k] = 0;
    m_count = 0;
    m_sel   = 0;
    m_age   = 0;
  endtask

  task automatic model_update(input bit rst_n, input bit d, input int v, input bit c, input bit p);
    if (!rst_n || c) begin
      model_reset();
    end else if (d) begin
      for (int k = DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = v;
      if (m_count < DEPTH) m_count++;
      m_sel = 0;
      m_age = 1;
    end else begin
      if (p) m_sel = (m_count == 0) ? 0 : (m_sel + 1) % m_count;
      if (m_age > 0 && m_age <= BURST) m_age++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sel_value"}, 32'(o_sel_value), (m_count == 0) ? 0 : m_hist[m_sel]);
    chk({tag, ".sel_idx"},   32'(o_sel_idx),   m_sel);
    chk({tag, ".count"},     32'(o_count),     m_count);
    chk({tag, ".full"},      32'(o_full),      32'(m_count == DEPTH));
    chk({tag, ".blank"},     32'(o_blank),     32'(exp_blank(m_age)));
  endtask

  // Drive one cycle of inputs, advance a clock, update the model, compare.
  task automatic step(input string tag, input bit d, input int v, input bit c, input bit p,
                      input bit rst_n = 1'b1);
    i_rst   = rst_n;
    i_done  = d;
    i_value = VALUE_W'(v);
    i_clear = c;
    i_prev  = p;
    @(posedge clk);
    model_update(rst_n, d, v, c, p);
    #1;
    check_all(tag);
  endtask

  initial begin
    int push_vals [5] = '{3, 7, 9, 2, 5};
    int scr_idx   [5] = '{1, 2, 3, 0, 1};
    int scr_val   [5] = '{2, 9, 7, 5, 2};
    model_reset();

    // 1: reset then idle
    step("rst", 0, 0, 0, 0, 1'b0);
    step("rst", 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0);
    chk("t1_count", 32'(o_count), 0);
    chk("t1_blank", 32'(o_blank), 0);

    // 2: five pushes into a depth-4 history
    for (int i = 0; i < 5; i++) step("push", 1, push_vals[i], 0, 0);
    chk("t2_count", 32'(o_count), 4);
    chk("t2_full", 32'(o_full), 1);
    chk("t2_sel_value", 32'(o_sel_value), 5);

    // 3: scroll through and wrap, then push snaps back to newest
    for (int i = 0; i < 5; i++) begin
      step("prev", 0, 0, 0, 1);
      chk("t3_idx", 32'(o_sel_idx), scr_idx[i]);
      chk("t3_val", 32'(o_sel_value), scr_val[i]);
    end
    step("push8", 1, 8, 0, 0);
    chk("t3_idx_after_push", 32'(o_sel_idx), 0);
    chk("t3_val_after_push", 32'(o_sel_value), 8);

    // 4: blink pattern, restarted by a push during the burst
    for (int i = 0; i < 30; i++) step("settle", 0, 0, 0, 0);
    step("push6", 1, 6, 0, 0);
    chk("t4_blank_c1", 32'(o_blank), 1);
    for (int n = 2; n <= 10; n++) begin
      step("burst", 0, 0, 0, 0);
      chk("t4_blank_pattern", 32'(o_blank), 32'((n <= 4) || (n >= 9)));
    end
    step("push1", 1, 1, 0, 0);
    chk("t4_restart_blank", 32'(o_blank), 1);
    for (int n = 2; n <= BURST + 6; n++) begin
      step("burst2", 0, 0, 0, 0);
      chk("t4_burst2", 32'(o_blank), 32'((n <= BURST) && (((n - 1) / HALF) % 2 == 0)));
    end

    // 5: clear + push + scroll together on a full history
    step("simul", 1, 4, 1, 1);
    chk("t5_count", 32'(o_count), 0);
    chk("t5_sel_value", 32'(o_sel_value), 0);
    chk("t5_blank", 32'(o_blank), 0);

    // 6: reset in the middle of a burst overrides a push in the same cycle
    step("p1", 1, 1, 0, 0);
    step("p2", 1, 2, 0, 0);
    step("mid", 0, 0, 0, 0);
    chk("t6_count_pre", 32'(o_count), 2);
    step("rst_mid", 1, 7, 0, 0, 1'b0);
    chk("t6_count_rst", 32'(o_count), 0);
    chk("t6_blank_rst", 32'(o_blank), 0);
    chk("t6_val_rst", 32'(o_sel_value), 0);
    step("p3", 1, 3, 0, 0);
    chk("t6_count", 32'(o_count), 1);
    chk("t6_val", 32'(o_sel_value), 3);

    // Random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           ($urandom % 8) == 0,
           int'($urandom % (1 << VALUE_W)),
           ($urandom % 40) == 0,
           ($urandom % 3) == 0,
           ($urandom % 250) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
